// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg
//   Shared types and geometry for the cache-line-to-burst adaptor.
//   LINE_W      : cache line width in bits
//   BURST_W     : memory beat width in bits
//   BEATS       : beats per line (LINE_W / BURST_W, must be 4)
//   OFFSET_BITS : byte-offset bits dropped to line-align an address
//   cla_state_t : adaptor FSM states
package cacheline_adaptor_pkg;

   localparam int LINE_W      = 256;
   localparam int BURST_W     = 64;
   localparam int BEATS       = LINE_W / BURST_W;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if
//   Bundles the cache-side line port and the memory-side burst port.
//   Cache side : line_i, line_o, address_i, read_i, write_i, resp_o
//   Memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   slave  : view taken by the adaptor
//   master : view taken by the surrounding cache/memory environment
interface cacheline_adaptor_if;
   import cacheline_adaptor_pkg::*;

   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   logic [31:0]        address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;

   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [31:0]        address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/cacheline_adaptor_line_buffer.sv
// line_buffer
//   NBEATS x BEAT_W register file holding one cache line.
//   clk, rst    : clock, asynchronous active-low reset (clears to 0)
//   load/line_i : load the whole line at once (takes priority over we)
//   we/wbeat/wdata : write one beat
//   rbeat/rdata : read one beat
//   line_o      : full line, beat 0 in the low bits
module line_buffer #(
   parameter int NBEATS = 4,
   parameter int BEAT_W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [NBEATS*BEAT_W-1:0]   line_i,
   input  logic                       we,
   input  logic [$clog2(NBEATS)-1:0]  wbeat,
   input  logic [BEAT_W-1:0]          wdata,
   input  logic [$clog2(NBEATS)-1:0]  rbeat,
   output logic [BEAT_W-1:0]          rdata,
   output logic [NBEATS*BEAT_W-1:0]   line_o
);

   logic [NBEATS-1:0][BEAT_W-1:0] mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else if (load) begin
         mem <= line_i;
      end else if (we) begin
         mem[wbeat] <= wdata;
      end
   end

   assign rdata  = mem[rbeat];
   assign line_o = mem;

endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Serves one 256-bit line read or write from the cache as a 4-beat,
//   64-bit ascending burst on the memory bus, then pulses resp_o.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : cacheline_adaptor_if.slave (cache line port + memory burst port)
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cacheline_adaptor_if.slave bus
);

   localparam int CNT_W = $clog2(BEATS);

   cla_state_t          state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [31:0]         addr_q;
   logic                last_beat;
   logic                beat_xfer;
   logic                start;
   logic                buf_load;
   logic                buf_we;
   logic [BURST_W-1:0]  rd_beat;
   logic [LINE_W-1:0]   buf_line;
   logic [OFFSET_BITS-1:0] unused_offset;

   // Byte offset within the line is dropped when aligning the address.
   assign unused_offset = bus.address_i[OFFSET_BITS-1:0];

   assign last_beat = (cnt == CNT_W'(BEATS - 1));
   assign beat_xfer = ((state == READ) || (state == WRITE)) && bus.resp_i;
   assign start     = (state == IDLE) && (bus.write_i || bus.read_i);
   // write_i wins when both requests arrive together, so only it loads.
   assign buf_load  = (state == IDLE) && bus.write_i;
   assign buf_we    = (state == READ) && bus.resp_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.write_i)     state_nxt = WRITE;
            else if (bus.read_i) state_nxt = READ;
         end
         READ, WRITE: begin
            if (bus.resp_i && last_beat) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         addr_q <= '0;
      end else if (start) begin
         cnt    <= '0;
         addr_q <= {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end else if (beat_xfer) begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

   line_buffer #(
      .NBEATS (BEATS),
      .BEAT_W (BURST_W)
   ) u_line_buffer (
      .clk    (clk),
      .rst    (rst),
      .load   (buf_load),
      .line_i (bus.line_i),
      .we     (buf_we),
      .wbeat  (cnt),
      .wdata  (bus.burst_i),
      .rbeat  (cnt),
      .rdata  (rd_beat),
      .line_o (buf_line)
   );

   // Every output is a decode of state or a register; no input reaches an
   // output combinationally.
   always_comb begin
      bus.read_o  = 1'b0;
      bus.write_o = 1'b0;
      bus.resp_o  = 1'b0;
      bus.burst_o = '0;
      case (state)
         READ:  bus.read_o = 1'b1;
         WRITE: begin
            bus.write_o = 1'b1;
            bus.burst_o = rd_beat;
         end
         DONE:  bus.resp_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.address_o = addr_q;
   assign bus.line_o    = buf_line;

endmodule
